// File: rtl/wb_trace_fifo.sv
// Writeback commit trace FIFO: records {PC, Rd, data} of every non-r0 register write
// into a show-ahead circular buffer drained over valid/ready. Define TRACE_STAMP_EN to add cycle stamps.
module wb_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          Clk,
   input  logic          Clrn,
   input  logic          W_Wreg,
   input  logic [4:0]    W_Rd,
   input  logic [31:0]   W_RegDin,
   input  logic [31:0]   W_PC,
   input  logic          Clear,
   input  logic          Rd_Ready,
   output logic          Rd_Valid,
   output logic [31:0]   Rd_PC,
   output logic [4:0]    Rd_Reg,
   output logic [31:0]   Rd_Data,
   output logic [15:0]   Rd_Stamp,
   output logic [AW:0]   Count,
   output logic          Overflow,
   output logic [7:0]    Drop_Cnt
);

`ifdef TRACE_STAMP_EN
   localparam int EW = 85;
`else
   localparam int EW = 69;
`endif
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic [7:0]    r_drop;

   logic          w_push;
   logic          w_valid;
   logic          w_pop;
   logic          w_full;
   logic          w_wr;
   logic          w_drop;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_head;

   assign w_push  = W_Wreg && (W_Rd != 5'd0);
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid && Rd_Ready && !Clear;
   assign w_full  = (r_count == FULL_CNT);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_wr    = w_push && !Clear && (!w_full || w_pop);
   assign w_drop  = w_push && !Clear && w_full && !w_pop;

`ifdef TRACE_STAMP_EN
   logic [15:0] r_stamp;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) r_stamp <= '0;
      else       r_stamp <= r_stamp + 16'd1;
   end

   assign w_entry  = {r_stamp, W_PC, W_Rd, W_RegDin};
   assign Rd_Stamp = w_valid ? w_head[84:69] : 16'd0;
`else
   assign w_entry  = {W_PC, W_Rd, W_RegDin};
   assign Rd_Stamp = 16'd0;
`endif

   // Storage array is data only and is deliberately left unreset.
   always_ff @(posedge Clk) begin
      if (w_wr) r_mem[r_wp] <= w_entry;
   end

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_drop  <= '0;
      end else if (Clear) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_drop  <= '0;
      end else begin
         if (w_wr)  r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign w_head   = r_mem[r_rp];
   assign Rd_Valid = w_valid;
   assign Rd_PC    = w_valid ? w_head[68:37] : 32'd0;
   assign Rd_Reg   = w_valid ? w_head[36:32] : 5'd0;
   assign Rd_Data  = w_valid ? w_head[31:0]  : 32'd0;
   assign Count    = r_count;
   assign Overflow = r_ovf;
   assign Drop_Cnt = r_drop;

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Hardware trace recorder on the writeback side of the pipelined CPU. Each cycle the W stage commits a register write, it captures {PC, destination register, write data} into a circular show-ahead FIFO. A debug reader or testbench drains the FIFO over a valid/ready port, so commit order can be checked against a golden model without probing internal pipeline nets.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2
- AW, 4, pointer width; log2(DEPTH)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Clrn  in  1  asynchronous active-low reset
- W_Wreg  in  1  writeback register-write enable, W stage
- W_Rd  in  5  writeback destination register number
- W_RegDin  in  32  writeback data
- W_PC  in  32  PC of the committing instruction
- Clear  in  1  synchronous flush
- Rd_Ready  in  1  reader accepts head entry
- Rd_Valid  out  1  head entry present
- Rd_PC  out  32  head PC
- Rd_Reg  out  5  head register number
- Rd_Data  out  32  head write data
- Rd_Stamp  out  16  head cycle stamp (see Configuration)
- Count  out  AW+1  occupancy, 0..DEPTH
- Overflow  out  1  sticky: an entry was dropped
- Drop_Cnt  out  8  dropped-entry count, saturates at 255

## Operation
- Push condition: W_Wreg=1 and W_Rd≠0. Writes to r0 are never recorded.
- Pop condition: Rd_Valid=1 and Rd_Ready=1.
- Storage: DEPTH-entry array, write pointer wp, read pointer rp, both AW bits, wrapping DEPTH-1→0. Count is held as a separate register, not derived from pointers.
- Show-ahead read: Rd_* reflect entry[rp] combinationally whenever Count≠0. When Count=0, Rd_Valid=0 and Rd_PC/Rd_Reg/Rd_Data/Rd_Stamp are forced to 0.
- Full (Count=DEPTH) with push and no pop:
  - entry is dropped; wp and Count are unchanged;
  - Overflow is set;
  - Drop_Cnt increments, saturating at 255.
- Full with push and pop in the same cycle: both are performed. Count stays DEPTH and no drop occurs.
- Empty with push and Rd_Ready=1: no pop, because Rd_Valid=0. Count becomes 1.
- Push and pop with 0<Count<DEPTH: both are performed and Count is unchanged.
- Clear=1 has priority over push and pop that cycle. It zeroes wp, rp, Count, Overflow and Drop_Cnt. The entry presented that cycle is discarded and is not counted as a drop.
- Clrn=0, asynchronous, at any time (including mid-drain) sets:
  - wp=rp=0, Count=0, Overflow=0, Drop_Cnt=0, stamp counter=0;
  - therefore Rd_Valid=0 and all Rd_* = 0.
- The array contents are not reset.

## Timing
- Capture latency is 1 cycle. A push sampled at edge N makes the entry visible on Rd_* with Rd_Valid=1 after edge N, provided the FIFO was empty.
- Pop takes effect at the edge where Rd_Valid and Rd_Ready are both high. The next entry, or Rd_Valid=0, appears after that edge.
- Count, Overflow and Drop_Cnt are registered and update on the same edge as the event that changes them.
- Rd_Valid does not depend combinationally on Rd_Ready.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- TRACE_STAMP_EN defined:
  - a free-running 16-bit cycle counter runs from reset, incrementing every Clk and wrapping 0xFFFF→0x0000; Clear does not affect it;
  - each entry stores the counter value at its push edge;
  - Rd_Stamp presents the head entry's stamp;
  - entry width is 85 bits.
- TRACE_STAMP_EN undefined:
  - no counter is built and entries are 69 bits;
  - Rd_Stamp is tied to 0.

## Test plan
- Reset, then push (W_Rd=5, W_RegDin=0x0000_00AA, W_PC=0x0000_0004) with Rd_Ready=0 → after one edge: Rd_Valid=1, Rd_Reg=5, Rd_Data=0xAA, Rd_PC=4, Count=1.
- Push with W_Rd=0, and a cycle with W_Wreg=0 and W_Rd=7 → Count unchanged, Rd_Valid stays 0.
- 18 consecutive pushes (data 1..18) into DEPTH=16 with Rd_Ready=0 → Count=16, Overflow=1, Drop_Cnt=2; draining yields data 1..16 in order, then Rd_Valid=0.
- When full, push data 0x55 with Rd_Ready=1 in the same cycle → head 1 popped, 0x55 stored at the tail, Count=16, Drop_Cnt unchanged; after the full drain, the last entry is 0x55.
- Assert Clear while Count=9 and Overflow=1, with a simultaneous push → next cycle Count=0, Overflow=0, Drop_Cnt=0, Rd_Valid=0; pulse Clrn low mid-drain → all outputs 0 immediately, without waiting for a clock edge.
- With TRACE_STAMP_EN, push at cycles 3 and 10 after reset release → popped Rd_Stamp values differ by 7. Without the macro → Rd_Stamp=0 throughout.
